// File: rtl/layer2_scheduler_pkg.sv
// Shared constants, ternary encodings and state type for the Layer 2 scheduler.
// Logits are signed two's complement; LOGIT_MIN seeds the argmax search.
package layer2_scheduler_pkg;

  localparam int N_OUT   = 10;
  localparam int N_IN    = 48;
  localparam int LOGIT_W = 6;
  localparam int WADDR_W = 9;
  localparam int IDX_W   = 4;
  localparam int MAC_W   = 6;

  // Ternary weight / neuron input encoding
  localparam logic [1:0] TW_ZERO  = 2'b00;
  localparam logic [1:0] TW_POS   = 2'b01;
  localparam logic [1:0] TW_ZERO2 = 2'b10;
  localparam logic [1:0] TW_NEG   = 2'b11;

  localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = {1'b1, {(LOGIT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_RELEASE,
    S_FINISH
  } l2_state_e;

  function automatic logic [1:0] act_to_input(input logic act);
    return act ? TW_POS : TW_NEG;
  endfunction

endpackage

// File: rtl/l2_argmax_tracker.sv
// Running argmax over a stream of signed values; strict greater-than keeps
// the earliest index on ties.
module l2_argmax_tracker
  import layer2_scheduler_pkg::*;
#(
  parameter int IW = IDX_W,
  parameter int VW = LOGIT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 valid_i,
  input  logic [IW-1:0]        idx_i,
  input  logic signed [VW-1:0] value_i,
  output logic [IW-1:0]        best_idx_o,
  output logic signed [VW-1:0] best_val_o
);

  localparam logic signed [VW-1:0] VMIN = {1'b1, {(VW-1){1'b0}}};

  logic [IW-1:0]        best_idx_q, best_idx_d;
  logic signed [VW-1:0] best_val_q, best_val_d;

  always_comb begin
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (clear_i) begin
      best_idx_d = '0;
      best_val_d = VMIN;
    end else if (valid_i && (value_i > best_val_q)) begin
      best_idx_d = idx_i;
      best_val_d = value_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_idx_q <= '0;
      best_val_q <= VMIN;
    end else begin
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  assign best_idx_o = best_idx_q;
  assign best_val_o = best_val_q;

endmodule

// File: rtl/layer2_scheduler.sv
// Time-multiplexes one layer2_neuron over all output classes, collecting
// logits and the argmax class from latched Layer 1 activations.
module layer2_scheduler
  import layer2_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N_IN-1:0]             act_bits,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W-1:0]            class_idx,
  output logic signed [LOGIT_W-1:0]   max_logit,
  output logic [N_OUT*LOGIT_W-1:0]    logits,
  output logic                        n_start,
  output logic [1:0]                  n_input,
  input  logic                        n_done,
  input  logic signed [LOGIT_W-1:0]   n_result,
  input  logic [MAC_W-1:0]            n_mac_count,
  output logic [WADDR_W-1:0]          w_addr,
  output logic [IDX_W-1:0]            b_addr
);

  l2_state_e                        st_q, st_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [N_IN-1:0]                  act_q, act_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             nst_q, nst_d;
  logic [IDX_W-1:0]                 cls_q, cls_d;
  logic signed [LOGIT_W-1:0]        maxl_q, maxl_d;
  logic [N_OUT-1:0][LOGIT_W-1:0]    lg_q, lg_d;

  logic                             trk_clear, trk_valid;
  logic [IDX_W-1:0]                 best_idx;
  logic signed [LOGIT_W-1:0]        best_val;

  l2_argmax_tracker #(.IW(IDX_W), .VW(LOGIT_W)) u_argmax (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (trk_clear),
    .valid_i    (trk_valid),
    .idx_i      (idx_q),
    .value_i    (n_result),
    .best_idx_o (best_idx),
    .best_val_o (best_val)
  );

  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    act_d     = act_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nst_d     = nst_q;
    cls_d     = cls_q;
    maxl_d    = maxl_q;
    lg_d      = lg_q;
    trk_clear = 1'b0;
    trk_valid = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          act_d     = act_bits;
          busy_d    = 1'b1;
          idx_d     = '0;
          trk_clear = 1'b1;
          st_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        nst_d = 1'b1;
        st_d  = S_RUN;
      end
      S_RUN: begin
        if (n_done) st_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        lg_d[idx_q] = n_result;
        trk_valid   = 1'b1;
        nst_d       = 1'b0;
        st_d        = S_RELEASE;
      end
      S_RELEASE: begin
        // Neuron must be back in idle before the next start is raised
        if (!n_done) begin
          if (idx_q == IDX_W'(N_OUT - 1)) begin
            st_d = S_FINISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            nst_d = 1'b1;
            st_d  = S_RUN;
          end
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        cls_d  = best_idx;
        maxl_d = best_val;
        busy_d = 1'b0;
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      idx_q  <= '0;
      act_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      nst_q  <= 1'b0;
      cls_q  <= '0;
      maxl_q <= '0;
      lg_q   <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      busy_q <= busy_d;
      done_q <= done_d;
      nst_q  <= nst_d;
      cls_q  <= cls_d;
      maxl_q <= maxl_d;
      lg_q   <= lg_d;
    end
  end

  // MAC indices past N_IN are don't-care; drive +1
  always_comb begin
    n_input = TW_POS;
    if (n_mac_count < MAC_W'(N_IN)) n_input = act_to_input(act_q[n_mac_count]);
  end

  assign w_addr    = WADDR_W'(idx_q) * WADDR_W'(N_IN) + WADDR_W'(n_mac_count);
  assign b_addr    = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign n_start   = nst_q;
  assign class_idx = cls_q;
  assign max_logit = maxl_q;
  assign logits    = lg_q;

endmodule

// File: tb/tb_layer2_scheduler.sv
// Directed bench: behavioural neuron + weight/bias ROMs around the scheduler,
// hand-computed logits and argmax per scenario.
module tb_layer2_scheduler;
  import layer2_scheduler_pkg::*;

  logic                       clk, rst_n, start;
  logic [N_IN-1:0]            act_bits;
  logic                       busy, done, n_start, n_done;
  logic [IDX_W-1:0]           class_idx, b_addr;
  logic signed [LOGIT_W-1:0]  max_logit, n_result;
  logic [N_OUT*LOGIT_W-1:0]   logits;
  logic [1:0]                 n_input;
  logic [MAC_W-1:0]           n_mac_count;
  logic [WADDR_W-1:0]         w_addr;

  int n_chk = 0;
  int n_fail = 0;

  layer2_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act_bits(act_bits),
    .busy(busy), .done(done), .class_idx(class_idx), .max_logit(max_logit),
    .logits(logits), .n_start(n_start), .n_input(n_input), .n_done(n_done),
    .n_result(n_result), .n_mac_count(n_mac_count), .w_addr(w_addr), .b_addr(b_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROMs and behavioural neuron: start -> 48 MACs -> bias add -> done held until start drops
  logic [1:0]               wrom [0:N_OUT*N_IN-1];
  logic signed [LOGIT_W-1:0] brom [0:N_OUT-1];
  logic [1:0] wt;
  assign wt = (int'(w_addr) < N_OUT*N_IN) ? wrom[w_addr] : 2'b00;

  function automatic int tern(input logic [1:0] v);
    return (v == 2'b01) ? 1 : (v == 2'b11) ? -1 : 0;
  endfunction

  typedef enum logic [1:0] {NI, NM, NA, ND} nmod_e;
  nmod_e nst;
  logic [5:0] mcnt;
  int acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      nst <= NI; mcnt <= '0; acc <= 0; n_result <= '0;
    end else begin
      case (nst)
        NI: if (n_start) begin nst <= NM; mcnt <= '0; acc <= 0; end
        NM: begin
          acc  <= acc + tern(n_input) * tern(wt);
          mcnt <= mcnt + 6'd1;
          if (mcnt == 6'd47) nst <= NA;
        end
        NA: begin n_result <= 6'(acc + int'(brom[b_addr])); nst <= ND; end
        ND: if (!n_start) begin nst <= NI; mcnt <= '0; end
        default: nst <= NI;
      endcase
    end
  end
  assign n_done      = (nst == ND);
  assign n_mac_count = mcnt;

  // Protocol watch: start must never rise while the neuron still shows done
  logic nst_prev;
  int   viol = 0;
  always @(posedge clk) begin
    nst_prev <= n_start;
    if (rst_n && n_start && !nst_prev && n_done) viol <= viol + 1;
  end

  task automatic run_inf(input int poke, input int flip_at, output int lat,
                         output int ndone, output logic busy_nxt);
    int post;
    bit seen;
    ndone = 0; lat = 0; busy_nxt = 1'b1; post = 0; seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 1; t < 800 && post < 8; t++) begin
      if (seen) begin post++; if (post == 1) busy_nxt = busy; end
      if (done) begin ndone++; if (!seen) lat = t; seen = 1'b1; end
      start = (t == poke);
      if (t == flip_at) act_bits = '0;
      @(negedge clk);
    end
    start = 1'b0;
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL done_timeout: done not seen within 800 cycles"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; act_bits = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({busy, done, n_start} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ctrl: busy/done/n_start=%b want 000", {busy, done, n_start}); end
    n_chk++; if (logits !== '0) begin n_fail++; $display("FAIL reset_logits: got %h want 0", logits); end
    n_chk++; if ({class_idx, max_logit} !== '0) begin n_fail++;
      $display("FAIL reset_class: class=%0d max=%0d want 0 0", class_idx, max_logit); end
  endtask

  task automatic test_wrap();
    int lat, nd; logic bn; logic [5:0] got, ex;
    for (int i = 0; i < N_OUT*N_IN; i++) wrom[i] = (i / N_IN == 3) ? 2'b01 : 2'b00;
    for (int k = 0; k < N_OUT; k++) brom[k] = '0;
    act_bits = '1;
    run_inf(-1, -1, lat, nd, bn);
    for (int k = 0; k < N_OUT; k++) begin
      got = logits[k*LOGIT_W +: LOGIT_W];
      ex  = (k == 3) ? 6'b110000 : 6'b000000;
      n_chk++; if (got !== ex) begin n_fail++;
        $display("FAIL wrap_logit[%0d]: got %0d want %0d", k, $signed(got), $signed(ex)); end
    end
    n_chk++; if (class_idx !== 4'd0 || max_logit !== 6'sd0) begin n_fail++;
      $display("FAIL wrap_argmax: class=%0d max=%0d want 0 0", class_idx, max_logit); end
  endtask

  task automatic test_ramp(input int poke, input string tag);
    int lat, nd; logic bn; logic [5:0] got, ex;
    for (int i = 0; i < N_OUT*N_IN; i++) wrom[i] = ((i % N_IN) <= (i / N_IN)) ? 2'b01 : 2'b00;
    for (int k = 0; k < N_OUT; k++) brom[k] = '0;
    act_bits = '1;
    run_inf(poke, -1, lat, nd, bn);
    for (int k = 0; k < N_OUT; k++) begin
      got = logits[k*LOGIT_W +: LOGIT_W];
      ex  = 6'(k + 1);
      n_chk++; if (got !== ex) begin n_fail++;
        $display("FAIL %s_logit[%0d]: got %0d want %0d", tag, k, $signed(got), $signed(ex)); end
    end
    n_chk++; if (class_idx !== 4'd9 || max_logit !== 6'sd10) begin n_fail++;
      $display("FAIL %s_argmax: class=%0d max=%0d want 9 10", tag, class_idx, max_logit); end
    n_chk++; if (nd !== 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", tag, nd); end
    n_chk++; if (bn !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after_done: got %b want 0", tag, bn); end
    n_chk++; if (lat > 560) begin n_fail++; $display("FAIL %s_latency: got %0d want <=560", tag, lat); end
  endtask

  task automatic test_ties();
    int lat, nd; logic bn; logic [5:0] got;
    for (int i = 0; i < N_OUT*N_IN; i++) wrom[i] = 2'b00;
    for (int k = 0; k < N_OUT; k++) brom[k] = 6'sd2;
    act_bits = 48'h0F0F_3C3C_A5A5;
    run_inf(-1, -1, lat, nd, bn);
    for (int k = 0; k < N_OUT; k++) begin
      got = logits[k*LOGIT_W +: LOGIT_W];
      n_chk++; if (got !== 6'd2) begin n_fail++;
        $display("FAIL ties_logit[%0d]: got %0d want 2", k, $signed(got)); end
    end
    n_chk++; if (class_idx !== 4'd0 || max_logit !== 6'sd2) begin n_fail++;
      $display("FAIL ties_argmax: class=%0d max=%0d want 0 2", class_idx, max_logit); end
  endtask

  task automatic setup_mixed();
    for (int i = 0; i < N_OUT*N_IN; i++) wrom[i] = 2'b01;
    for (int k = 0; k < N_OUT; k++) brom[k] = (k == 5) ? 6'sd7 : 6'sd0;
    act_bits = 48'h5555_5555_5555;
  endtask

  task automatic test_mixed_signs(input int flip_at, input string tag);
    int lat, nd; logic bn; logic [5:0] got, ex;
    setup_mixed();
    run_inf(-1, flip_at, lat, nd, bn);
    for (int k = 0; k < N_OUT; k++) begin
      got = logits[k*LOGIT_W +: LOGIT_W];
      ex  = (k == 5) ? 6'd7 : 6'd0;
      n_chk++; if (got !== ex) begin n_fail++;
        $display("FAIL %s_logit[%0d]: got %0d want %0d", tag, k, $signed(got), $signed(ex)); end
    end
    n_chk++; if (class_idx !== 4'd5 || max_logit !== 6'sd7) begin n_fail++;
      $display("FAIL %s_argmax: class=%0d max=%0d want 5 7", tag, class_idx, max_logit); end
    n_chk++; if (nd !== 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", tag, nd); end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < N_OUT*N_IN; i++) wrom[i] = 2'b01;
    for (int k = 0; k < N_OUT; k++) brom[k] = 6'sd3;
    act_bits = '1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (199) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++; if ({busy, n_start, done} !== 3'b000) begin n_fail++;
      $display("FAIL midrun_reset_ctrl: busy/n_start/done=%b want 000", {busy, n_start, done}); end
    n_chk++; if (logits !== '0) begin n_fail++; $display("FAIL midrun_reset_logits: got %h want 0", logits); end
    @(negedge clk);
    test_mixed_signs(-1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_ramp(-1, "ramp");
    test_ties();
    test_mixed_signs(60, "mixed");
    test_ramp(100, "restart_ignored");
    test_reset_mid_run();
    n_chk++; if (viol !== 0) begin n_fail++;
      $display("FAIL start_while_done: %0d violations want 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer2_scheduler.md
Name: layer2_scheduler

Overview:
- Sequences one shared layer2_neuron datapath over all output classes: N_OUT neurons × N_IN inputs.
- Latches the 48 binary Layer 1 activations and drives each neuron run's input, weight address and bias address.
- Captures each raw 6-bit logit and tracks a running argmax.
- Sits between the Layer 1 output register and the top-level result/readout logic.

Parameters:
N_OUT, 10, number of output neurons (classes) run sequentially
N_IN, 48, inputs per neuron; must match the neuron's fixed MAC count
LOGIT_W, 6, signed logit width returned by the neuron
WADDR_W, 9, weight address width (ceil log2(N_OUT*N_IN))
IDX_W, 4, class index width (ceil log2(N_OUT))

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin inference; sampled only in IDLE
act_bits  in  N_IN  Layer 1 activations; bit=1 means +1, bit=0 means -1
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all logits and class are valid
class_idx  out  IDX_W  argmax class, held until next accepted start
max_logit  out  LOGIT_W  signed logit of class_idx
logits  out  N_OUT*LOGIT_W  flat logit array, class k at bits [k*6+5:k*6]
n_start  out  1  neuron start (registered)
n_input  out  2  signed neuron input for current MAC (combinational)
n_done  in  1  neuron done
n_result  in  LOGIT_W  neuron signed logit
n_mac_count  in  6  neuron current MAC index
w_addr  out  WADDR_W  weight ROM address (combinational); ROM returns 2-bit ternary weight straight to the neuron, same cycle
b_addr  out  IDX_W  bias ROM address = current neuron index

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - On rst_n=0 at posedge, the block goes to IDLE and clears busy, done, n_start, class_idx, max_logit, logits, the neuron index and the activation latch.
  - Reset mid-run abandons the run.
  - The same rst_n drives the neuron.
- States: IDLE, LOAD, RUN, CAPTURE, RELEASE, FINISH.
- IDLE:
  - start=1 → latch act_bits, set busy=1, neuron index=0, best logit=-32, best index=0, go to LOAD.
  - start while busy is ignored.
- LOAD: set n_start<=1, go to RUN.
- RUN: hold n_start=1 until n_done=1, then go to CAPTURE.
- CAPTURE:
  - Write n_result into logits slot [idx] and set n_start<=0.
  - Argmax update uses strict greater-than, so ties keep the lower index.
  - Go to RELEASE.
- RELEASE:
  - Wait until n_done=0, i.e. the neuron has returned to its IDLE state.
  - If idx==N_OUT-1, go to FINISH.
  - Otherwise increment idx and set n_start<=1 (go to RUN).
  - Start must never be re-raised while n_done is still high.
- FINISH: pulse done for 1 cycle, update class_idx and max_logit, set busy<=0, go to IDLE.
- Combinational drives:
  - n_input = 2'b01 if act_latch[n_mac_count] else 2'b11.
  - n_mac_count ≥ N_IN → n_input=2'b01 (don't-care).
  - w_addr = idx*N_IN + n_mac_count.
  - b_addr = idx.
- Arithmetic: logits are signed two's complement; argmax comparison is signed.
- Timing:
  - Nominal 54 cycles per neuron with the layer2_neuron timing.
  - Full inference completes within 560 cycles of the accepted start.
- Activation latch: act_bits changes during busy do not affect the result.

Decomposition:
- Shared package holds:
  - N_OUT, N_IN and LOGIT_W constants.
  - Ternary weight encoding: 00=0, 01=+1, 11=-1, 10=0.
  - Scheduler state enum.
  - LOGIT_MIN = -32.
- One sub-module is natural: l2_argmax_tracker.
  - Interface: clear, valid, idx, value in; best_idx and best_val out.
  - Strict-greater update rule.

Test Plan:
- act_bits all 1, weight ROM all +1 for class 3 only (other classes 0), biases 0 → logits[3]=truncated 48 (6-bit, i.e. -16), others 0; class_idx=0 because 0 > -16 and ties resolve to the lowest index.
- Weights for class k: first (k+1) entries +1, rest 0; act all 1; bias 0 → logits[k]=k+1, class_idx=9, max_logit=10, done pulses exactly once, busy low the cycle after done.
- All logits equal (all weights 0, all biases +2) → every logit=2, class_idx=0.
- Mixed signs: act alternating 1/0, weights all +1, class 5 bias +7, others bias 0 → logits = 0 except logits[5]=7, class_idx=5.
- start pulsed again mid-run at cycle 100 → ignored; single done; results identical to the undisturbed run.
- rst_n low for 1 cycle at cycle 200 → busy=0, n_start=0, logits=0 next cycle; new start then completes normally.
